// File: rtl/alu_arbiter.sv
// Round-robin scheduler for two requesters sharing one byte-serial ALU.
// Sequences clear/start/A/M loads, returns the result and aborts jobs whose finish never arrives.
module alu_arbiter #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] sel0,
    input  logic [1:0] sel1,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] m0,
    input  logic [7:0] m1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] result,
    output logic       busy,
    output logic       alu_rst,
    output logic       alu_start,
    output logic [1:0] alu_sel,
    output logic [7:0] alu_inbus,
    input  logic [7:0] alu_outbus,
    input  logic       alu_finish
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_A,
        S_HOLD_A,
        S_LOAD_M,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             gnt_q;
    logic             gnt_d;
    logic [1:0]       sel_q;
    logic [7:0]       a_q;
    logic [7:0]       m_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       result_q;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    assign gnt_d = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            sel_q    <= '0;
            a_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        gnt_q   <= gnt_d;
                        last_q  <= gnt_d;
                        sel_q   <= gnt_d ? sel1 : sel0;
                        a_q     <= gnt_d ? a1 : a0;
                        m_q     <= gnt_d ? m1 : m0;
                        state_q <= S_CLR;
                    end
                end
                S_CLR:    state_q <= S_LOAD_A;
                S_LOAD_A: state_q <= S_HOLD_A;
                S_HOLD_A: begin
                    cnt_q   <= '0;
                    state_q <= S_LOAD_M;
                end
                S_LOAD_M: begin
                    // Finish wins over the timeout on the same edge.
                    if (alu_finish) begin
                        result_q <= alu_outbus;
                        state_q  <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= '0;
                        state_q  <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign alu_rst   = rst || (state_q == S_CLR) || (state_q == S_ERR);
    assign alu_start = (state_q == S_LOAD_A);
    assign alu_sel   = busy ? sel_q : '0;
    assign result    = result_q;
    assign done0     = ((state_q == S_DONE) || (state_q == S_ERR)) && !gnt_q;
    assign done1     = ((state_q == S_DONE) || (state_q == S_ERR)) && gnt_q;
    assign err0      = (state_q == S_ERR) && !gnt_q;
    assign err1      = (state_q == S_ERR) && gnt_q;

    always_comb begin
        alu_inbus = '0;
        case (state_q)
            S_LOAD_A, S_HOLD_A: alu_inbus = a_q;
            S_LOAD_M:           alu_inbus = m_q;
            default:            alu_inbus = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural byte-serial ALU model
// whose finish delay (cycles after LOAD_M entry, -1 = never) is set per test.
module tb_alu_arbiter;

    localparam int unsigned TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] sel0 = '0, sel1 = '0;
    logic [7:0] a0 = '0, a1 = '0, m0 = '0, m1 = '0;
    logic       done0, done1, err0, err1, busy, alu_rst, alu_start;
    logic [7:0] result, alu_inbus;
    logic [1:0] alu_sel;
    logic [7:0] alu_outbus = '0;
    logic       alu_finish = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int alu_k = -1;
    int pc = 99;
    logic [7:0]  ma = '0;
    logic [1:0]  msel = '0;
    logic [11:0] sb[$];

    alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .sel0(sel0), .sel1(sel1),
        .a0(a0), .a1(a1), .m0(m0), .m1(m1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .result(result), .busy(busy),
        .alu_rst(alu_rst), .alu_start(alu_start), .alu_sel(alu_sel),
        .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_finish(alu_finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_fn(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y);
        case (s)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x ^ y;
        endcase
    endfunction

    // ALU model: latches A/sel at start, pc counts cycles since start, LOAD_M begins at pc=2.
    always @(negedge clk) begin
        if (rst || !busy) begin
            pc = 99;
            alu_finish = 1'b0;
        end else begin
            if (alu_start) begin
                pc = 0;
                ma = alu_inbus;
                msel = alu_sel;
            end else if (pc < 99) begin
                pc = pc + 1;
            end
            alu_finish = (alu_k >= 0) && (pc - 2 == alu_k);
            if (alu_finish) alu_outbus = alu_fn(msel, ma, alu_inbus);
        end
    end

    // Expected {done0, done1, err0, err1, result} for one job.
    function automatic logic [11:0] mk(input bit who, input bit err, input logic [7:0] res);
        return {~who, who, err & ~who, err & who, res};
    endfunction

    task automatic sb_pop(output logic [11:0] w);
        if (sb.size() == 0) w = 'x;
        else w = sb.pop_front();
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done0, done1, err0, err1, alu_start, alu_rst} !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=%b", {busy, done0, done1, err0, err1, alu_start, alu_rst}, 7'b0000001);
        end
        checks++;
        if ({result, alu_sel, alu_inbus} !== 18'd0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h want=00/0/00", result, alu_sel, alu_inbus);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, alu_rst} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got=%b want=00", {busy, alu_rst});
        end
    endtask

    task automatic test_single;
        logic [11:0] w;
        logic [7:0]  exp_in;
        alu_k = 3;
        @(negedge clk);
        sel0 = 2'd0; a0 = 8'd40; m0 = 8'd12; req0 = 1'b1;
        sb.push_back(mk(1'b0, 1'b0, 8'd52));
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            exp_in = (n == 2 || n == 3) ? 8'd40 : (n >= 4 && n <= 7) ? 8'd12 : 8'd0;
            checks++;
            if ({alu_rst, alu_start, busy, done0, done1} !== {n == 1, n == 2, n <= 8, n == 8, 1'b0}) begin
                failures++;
                $display("FAIL single_ctrl cycle=%0d got=%b want=%b", n,
                         {alu_rst, alu_start, busy, done0, done1}, {n == 1, n == 2, n <= 8, n == 8, 1'b0});
            end
            checks++;
            if (alu_inbus !== exp_in) begin
                failures++;
                $display("FAIL single_inbus cycle=%0d got=%0d want=%0d", n, alu_inbus, exp_in);
            end
            if (done0 || done1) begin
                req0 = 1'b0;
                sb_pop(w);
                checks++;
                if ({done0, done1, err0, err1, result} !== w) begin
                    failures++;
                    $display("FAIL single_result got=%h want=%h", {done0, done1, err0, err1, result}, w);
                end
            end
        end
    endtask

    task automatic test_finish_k0;
        bit got;
        int t0;
        logic [11:0] w;
        alu_k = 0;
        @(negedge clk);
        sel1 = 2'd1; a1 = 8'd40; m1 = 8'd12; req1 = 1'b1; t0 = cyc;
        sb.push_back(mk(1'b1, 1'b0, 8'd28));
        wait_done(12, got);
        req1 = 1'b0;
        checks++;
        if (!got || cyc != t0 + 5) begin
            failures++;
            $display("FAIL k0_latency got=%0d want=5", got ? cyc - t0 : -1);
        end
        sb_pop(w);
        checks++;
        if ({done0, done1, err0, err1, result} !== w) begin
            failures++;
            $display("FAIL k0_result got=%h want=%h", {done0, done1, err0, err1, result}, w);
        end
    endtask

    task automatic test_fairness;
        int n_done = 0;
        logic [11:0] w;
        logic [9:0]  exp_ld;
        alu_k = 1;
        @(negedge clk);
        sel0 = 2'd2; a0 = 8'hF0; m0 = 8'h3C;
        sel1 = 2'd3; a1 = 8'hAA; m1 = 8'h0F;
        req0 = 1'b1; req1 = 1'b1;
        for (int j = 0; j < 4; j++) sb.push_back(mk(j % 2 == 1, 1'b0, (j % 2 == 1) ? 8'hA5 : 8'h30));
        for (int i = 0; i < 60 && n_done < 4; i++) begin
            @(negedge clk);
            if (alu_start) begin
                exp_ld = (n_done % 2 == 1) ? {2'd3, 8'hAA} : {2'd2, 8'hF0};
                checks++;
                if ({alu_sel, alu_inbus} !== exp_ld) begin
                    failures++;
                    $display("FAIL fair_load job=%0d got=%h want=%h", n_done, {alu_sel, alu_inbus}, exp_ld);
                end
            end
            if (done0 || done1) begin
                sb_pop(w);
                checks++;
                if ({done0, done1, err0, err1, result} !== w) begin
                    failures++;
                    $display("FAIL fair_result job=%0d got=%h want=%h", n_done, {done0, done1, err0, err1, result}, w);
                end
                n_done++;
                if (n_done == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        checks++;
        if (n_done != 4) begin
            failures++;
            $display("FAIL fair_count got=%0d want=4", n_done);
        end
    endtask

    task automatic test_timeout;
        bit got;
        int t0;
        logic [11:0] w;
        alu_k = -1;
        @(negedge clk);
        sel1 = 2'd0; a1 = 8'd5; m1 = 8'd6; req1 = 1'b1; t0 = cyc;
        sb.push_back(mk(1'b1, 1'b1, 8'h00));
        wait_done(TIMEOUT + 10, got);
        req1 = 1'b0;
        checks++;
        if (!got || cyc != t0 + 4 + TIMEOUT) begin
            failures++;
            $display("FAIL to_latency got=%0d want=%0d", got ? cyc - t0 : -1, 4 + TIMEOUT);
        end
        checks++;
        if (alu_rst !== 1'b1) begin
            failures++;
            $display("FAIL to_alu_rst got=%b want=1", alu_rst);
        end
        sb_pop(w);
        checks++;
        if ({done0, done1, err0, err1, result} !== w) begin
            failures++;
            $display("FAIL to_result got=%h want=%h", {done0, done1, err0, err1, result}, w);
        end
        alu_k = 2;
        @(negedge clk);
        sel0 = 2'd0; a0 = 8'd1; m0 = 8'd2; req0 = 1'b1; t0 = cyc;
        sb.push_back(mk(1'b0, 1'b0, 8'd3));
        wait_done(15, got);
        req0 = 1'b0;
        checks++;
        if (!got || cyc != t0 + 7) begin
            failures++;
            $display("FAIL to_next_latency got=%0d want=7", got ? cyc - t0 : -1);
        end
        sb_pop(w);
        checks++;
        if ({done0, done1, err0, err1, result} !== w) begin
            failures++;
            $display("FAIL to_next_result got=%h want=%h", {done0, done1, err0, err1, result}, w);
        end
    endtask

    task automatic test_reset_midjob;
        bit got;
        logic [11:0] w;
        alu_k = -1;
        @(negedge clk);
        sel0 = 2'd0; a0 = 8'd7; m0 = 8'd9; req0 = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({busy, alu_inbus} !== {1'b1, 8'd9}) begin
            failures++;
            $display("FAIL rstmid_loadm got=%h want=109", {busy, alu_inbus});
        end
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        checks++;
        if ({busy, done0, done1, err0, err1, alu_start, alu_rst} !== 7'b0000001) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b want=%b", {busy, done0, done1, err0, err1, alu_start, alu_rst}, 7'b0000001);
        end
        checks++;
        if ({result, alu_sel, alu_inbus} !== 18'd0) begin
            failures++;
            $display("FAIL rstmid_data got=%h/%h/%h want=00/0/00", result, alu_sel, alu_inbus);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({done0, done1, err0, err1} !== 4'b0000) begin
                failures++;
                $display("FAIL rstmid_pulse got=%b want=0000", {done0, done1, err0, err1});
            end
        end
        rst = 1'b0;
        // Pointer is back to 1, so a tie must go to requester 0 first.
        alu_k = 0;
        @(negedge clk);
        sel0 = 2'd1; a0 = 8'd50; m0 = 8'd8;
        sel1 = 2'd1; a1 = 8'd100; m1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        sb.push_back(mk(1'b0, 1'b0, 8'd42));
        sb.push_back(mk(1'b1, 1'b0, 8'd99));
        for (int j = 0; j < 2; j++) begin
            wait_done(20, got);
            if (done0) req0 = 1'b0;
            if (done1) req1 = 1'b0;
            sb_pop(w);
            checks++;
            if (!got || {done0, done1, err0, err1, result} !== w) begin
                failures++;
                $display("FAIL rstmid_after job=%0d got=%h want=%h", j, {done0, done1, err0, err1, result}, w);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_drop;
        bit got;
        int t0;
        logic [11:0] w;
        alu_k = 2;
        @(negedge clk);
        sel0 = 2'd3; a0 = 8'h55; m0 = 8'hFF; req0 = 1'b1; t0 = cyc;
        sb.push_back(mk(1'b0, 1'b0, 8'hAA));
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, alu_start, alu_inbus} !== {2'b10, 8'h55}) begin
            failures++;
            $display("FAIL drop_holda got=%h want=255", {busy, alu_start, alu_inbus});
        end
        req0 = 1'b0;
        wait_done(12, got);
        checks++;
        if (!got || cyc != t0 + 7) begin
            failures++;
            $display("FAIL drop_latency got=%0d want=7", got ? cyc - t0 : -1);
        end
        sb_pop(w);
        checks++;
        if ({done0, done1, err0, err1, result} !== w) begin
            failures++;
            $display("FAIL drop_result got=%h want=%h", {done0, done1, err0, err1, result}, w);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done0, done1} !== 3'b000) begin
            failures++;
            $display("FAIL drop_retrigger got=%b want=000", {busy, done0, done1});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_finish_k0();
        test_fairness();
        test_timeout();
        test_reset_midjob();
        test_drop();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
